// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD subtractor: FSM state encoding,
// decimal digit limits and a helper that flags a nibble as a legal BCD digit.
// Latency: n/a (types and constants only). Backpressure: n/a.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;

  function automatic logic digit_valid(input logic [3:0] n);
    return (n <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One decimal digit of subtraction: d = x - y - b_in, folded back into 0..9.
// Latency: purely combinational. Backpressure: none.
// Ports: x, y (BCD digits), b_in (borrow in) -> d (BCD digit), b_out (borrow out).
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       b_in,
  output logic [3:0] d,
  output logic       b_out
);

  // Five bits so that a negative raw difference shows up in bit 4.
  logic [4:0] w_raw;

  assign w_raw = {1'b0, x} - {1'b0, y} - {4'd0, b_in};
  assign b_out = w_raw[4];
  // A negative digit is lifted by the radix; modulo 16 lands it in 0..9.
  assign d     = b_out ? (w_raw[3:0] + BCD_RADIX[3:0]) : w_raw[3:0];

endmodule

// File: rtl/bcd_sub8_seq.sv
// Two-digit packed-BCD subtractor computing A - B - borrow_in, one digit per cycle.
// Latency: done 2 edges after an accepted start (1 edge for out-of-range operands).
// Backpressure: start is only sampled in IDLE; starts while busy/done are dropped.
// Ports: clk, reset (async, active-high); start, A, B, borrow_in in;
//        busy, done, DIFF, borrow_out, out_of_range out (results held until next completion).
module bcd_sub8_seq
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       borrow_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] DIFF,
  output logic       borrow_out,
  output logic       out_of_range
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_bin;
  logic       r_inval;
  logic [3:0] r_lo;    // low digit parked here until the whole result is ready
  logic       r_brw;   // borrow carried from the low digit into the high digit
  logic [7:0] r_diff;
  logic       r_borrow_out;
  logic       r_oor;

  logic       w_inval;
  logic       w_busy;
  logic       w_done;
  logic [3:0] w_x;
  logic [3:0] w_y;
  logic       w_bi;
  logic [3:0] w_d;
  logic       w_bout;

  assign w_inval = !(digit_valid(A[3:0]) && digit_valid(A[7:4]) &&
                     digit_valid(B[3:0]) && digit_valid(B[7:4]));

  // Single digit slice shared between LO and HI; the state picks the nibbles.
  assign w_x  = (r_state == HI) ? r_a[7:4] : r_a[3:0];
  assign w_y  = (r_state == HI) ? r_b[7:4] : r_b[3:0];
  assign w_bi = (r_state == HI) ? r_brw    : r_bin;

  bcd_digit_sub u_digit (
    .x     (w_x),
    .y     (w_y),
    .b_in  (w_bi),
    .d     (w_d),
    .b_out (w_bout)
  );

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = LO;
      LO: begin
        w_busy = 1'b1;
        w_next = r_inval ? DONE : HI;
      end
      HI: begin
        w_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_a          <= 8'h00;
      r_b          <= 8'h00;
      r_bin        <= 1'b0;
      r_inval      <= 1'b0;
      r_lo         <= 4'h0;
      r_brw        <= 1'b0;
      r_diff       <= 8'h00;
      r_borrow_out <= 1'b0;
      r_oor        <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_bin   <= borrow_in;
            r_inval <= w_inval;
          end
        end
        LO: begin
          if (r_inval) begin
            r_diff       <= 8'h00;
            r_borrow_out <= 1'b0;
            r_oor        <= 1'b1;
          end else begin
            r_lo  <= w_d;
            r_brw <= w_bout;
          end
        end
        HI: begin
          r_diff       <= {w_d, r_lo};
          r_borrow_out <= w_bout;
          r_oor        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy         = w_busy;
  assign done         = w_done;
  assign DIFF         = r_diff;
  assign borrow_out   = r_borrow_out;
  assign out_of_range = r_oor;

endmodule

// File: tb/tb_bcd_sub8_seq.sv
// Directed-vector bench for bcd_sub8_seq with hand-computed expected results.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at that point too.
module tb_bcd_sub8_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       borrow_in;
  logic       busy;
  logic       done;
  logic [7:0] DIFF;
  logic       borrow_out;
  logic       out_of_range;

  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;
  logic [7:0] last_diff = 8'h00;

  bcd_sub8_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .A            (A),
    .B            (B),
    .borrow_in    (borrow_in),
    .busy         (busy),
    .done         (done),
    .DIFF         (DIFF),
    .borrow_out   (borrow_out),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] ed, input logic eb,
                        input logic eo, input int lat);
    int n;
    int c0;
    c0 = done_cnt;
    A = a; B = b; borrow_in = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); borrow_in = 1'($urandom);
    chk({tag, ":busy"}, busy, 1);
    n = 0;
    while (!done && n < 8) begin
      chk({tag, ":hold"}, DIFF, last_diff);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":lat"}, n, lat);
    chk({tag, ":diff"}, DIFF, ed);
    chk({tag, ":bo"}, borrow_out, eb);
    chk({tag, ":oor"}, out_of_range, eo);
    chk({tag, ":busy_done"}, busy, 0);
    last_diff = ed;
    @(posedge clk); #1;
    chk({tag, ":done_drop"}, done, 0);
    chk({tag, ":pulses"}, done_cnt - c0, 1);
    @(posedge clk); #1;
    chk({tag, ":idle_hold"}, DIFF, ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:diff", DIFF, 8'h00);
    chk("rst:bo", borrow_out, 0);
    chk("rst:oor", out_of_range, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("42-17",   8'h42, 8'h17, 1'b0, 8'h25, 1'b0, 1'b0, 2);
    run_op("17-42",   8'h17, 8'h42, 1'b0, 8'h75, 1'b1, 1'b0, 2);
    run_op("00-00-1", 8'h00, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, 2);
    run_op("3A-11",   8'h3A, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    run_op("99-99",   8'h99, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 2);
    run_op("80-01",   8'h80, 8'h01, 1'b0, 8'h79, 1'b0, 1'b0, 2);

    // start held high while busy, operands disturbed during LO and HI
    c0 = done_cnt;
    A = 8'h42; B = 8'h17; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 8'h99;
    @(posedge clk); #1;
    A = 8'h00; B = 8'h88; borrow_in = 1'b1;
    @(posedge clk); #1;
    chk("busy:done", done, 1);
    chk("busy:diff", DIFF, 8'h25);
    chk("busy:bo", borrow_out, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy:done_drop", done, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy:pulses", done_cnt - c0, 1);
    chk("busy:no_queue", busy, 0);
    last_diff = 8'h25;

    run_op("17-42b", 8'h17, 8'h42, 1'b0, 8'h75, 1'b1, 1'b0, 2);

    // asynchronous reset in the middle of the HI cycle
    c0 = done_cnt;
    A = 8'h42; B = 8'h17; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("arst:in_hi", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst:busy", busy, 0);
    chk("arst:done", done, 0);
    chk("arst:diff", DIFF, 8'h00);
    chk("arst:bo", borrow_out, 0);
    chk("arst:oor", out_of_range, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("arst:no_pulse", done_cnt - c0, 0);
    last_diff = 8'h00;

    run_op("55-05", 8'h55, 8'h05, 1'b0, 8'h50, 1'b0, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
